// File: rtl/ula_arbiter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ula_arbiter_ctrl_pkg
// Description : Shared definitions for the ALU arbiter: opcode constants,
//               controller state encoding and the opcode support check.
// Revision    : 1.0 - initial release
// ============================================================================
package ula_arbiter_ctrl_pkg;

    localparam logic [4:0] OP_PASS = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_MUL  = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_NAND = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_XOR  = 5'b01011;
    localparam logic [4:0] OP_CMP  = 5'b01100;
    localparam logic [4:0] OP_NOT  = 5'b01101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // PASS plus the contiguous block ADD..NOT are the only codes the ALU implements.
    function automatic logic opcode_supported(input logic [4:0] op);
        return (op == OP_PASS) || ((op >= OP_ADD) && (op <= OP_NOT));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ula_arbiter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ula_arbiter_ctrl_if
// Description : Bundle of the two request channels, two response channels,
//               the shared result bus and the ALU connection.
//               slave  : view of the arbiter (accepts requests, drives ALU)
//               master : view of the requesters and the ALU
// Revision    : 1.0 - initial release
// ============================================================================
interface ula_arbiter_ctrl_if;

    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_operando1;
    logic [15:0] req0_operando2;
    logic [4:0]  req0_opcode;

    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_operando1;
    logic [15:0] req1_operando2;
    logic [4:0]  req1_opcode;

    logic        resp0_valid;
    logic        resp0_ready;
    logic        resp1_valid;
    logic        resp1_ready;
    logic [31:0] resp_resultado;
    logic        resp_erro;

    logic [15:0] ula_operando1;
    logic [15:0] ula_operando2;
    logic [4:0]  ula_opcode;
    logic [31:0] ula_resultado;

    modport slave (
        input  req0_valid, req0_operando1, req0_operando2, req0_opcode,
        output req0_ready,
        input  req1_valid, req1_operando1, req1_operando2, req1_opcode,
        output req1_ready,
        output resp0_valid, resp1_valid, resp_resultado, resp_erro,
        input  resp0_ready, resp1_ready,
        output ula_operando1, ula_operando2, ula_opcode,
        input  ula_resultado
    );

    modport master (
        output req0_valid, req0_operando1, req0_operando2, req0_opcode,
        input  req0_ready,
        output req1_valid, req1_operando1, req1_operando2, req1_opcode,
        input  req1_ready,
        input  resp0_valid, resp1_valid, resp_resultado, resp_erro,
        output resp0_ready, resp1_ready,
        input  ula_operando1, ula_operando2, ula_opcode,
        output ula_resultado
    );

endinterface
`default_nettype wire

// File: rtl/ula_arbiter_ctrl_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : ula_rr_pick
// Description : Combinational two-way round-robin winner selection.
//               A lone requester always wins; on contention the requester
//               named by prio wins.
// Ports       : valid0, valid1 - request presence
//               prio           - 0: requester 0 favoured, 1: requester 1
//               grant0, grant1 - one-hot (or zero) winner
// Revision    : 1.0 - initial release
// ============================================================================
module ula_rr_pick (
    input  wire logic valid0,
    input  wire logic valid1,
    input  wire logic prio,
    output logic      grant0,
    output logic      grant1
);

    assign grant0 = valid0 & (~valid1 | ~prio);
    assign grant1 = valid1 & (~valid0 |  prio);

endmodule
`default_nettype wire

// File: rtl/ula_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ula_arbiter_ctrl
// Description : Shares one combinational 16-bit ALU between two requesters.
//               Round-robin arbitration, registered ALU operands, fixed
//               execution wait (longer for MUL/DIV), result returned on a
//               shared bus to the issuing requester. Unsupported opcodes and
//               divide-by-zero are answered with an error without using the ALU.
// Ports       : clock, reset - rising-edge clock, async active-high reset
//               bus (slave)  - request/response channels and ALU connection
// Revision    : 1.0 - initial release
// ============================================================================
module ula_arbiter_ctrl
    import ula_arbiter_ctrl_pkg::*;
#(
    parameter int ALU_CYCLES    = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input  wire logic          clock,
    input  wire logic          reset,
    ula_arbiter_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (ALU_CYCLES > MULDIV_CYCLES) ? ALU_CYCLES : MULDIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             r_state;
    logic               r_prio;
    logic               r_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_resp_valid;
    logic [31:0]        r_resp_resultado;
    logic               r_resp_erro;
    logic [15:0]        r_ula_operando1;
    logic [15:0]        r_ula_operando2;
    logic [4:0]         r_ula_opcode;

    logic               w_grant0;
    logic               w_grant1;
    logic               w_idle;
    logic               w_accept;
    logic               w_sel;
    logic [15:0]        w_op1;
    logic [15:0]        w_op2;
    logic [4:0]         w_opcode;
    logic               w_is_muldiv;
    logic               w_reject;
    logic               w_owner_resp_ready;

    ula_rr_pick u_pick (
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .prio   (r_prio),
        .grant0 (w_grant0),
        .grant1 (w_grant1)
    );

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle & (w_grant0 | w_grant1);
    assign w_sel    = w_grant1;

    // Ready is masked by reset so that every output reads zero while reset is held.
    assign bus.req0_ready = w_idle & w_grant0 & ~reset;
    assign bus.req1_ready = w_idle & w_grant1 & ~reset;

    assign w_op1    = w_sel ? bus.req1_operando1 : bus.req0_operando1;
    assign w_op2    = w_sel ? bus.req1_operando2 : bus.req0_operando2;
    assign w_opcode = w_sel ? bus.req1_opcode    : bus.req0_opcode;

    assign w_is_muldiv = (w_opcode == OP_MUL) || (w_opcode == OP_DIV);
    assign w_reject    = ~opcode_supported(w_opcode) ||
                         ((w_opcode == OP_DIV) && (w_op2 == 16'd0));

    // Only the owner's response-ready matters; the other requester is ignored.
    assign w_owner_resp_ready = r_owner ? bus.resp1_ready : bus.resp0_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_prio           <= 1'b0;
            r_owner          <= 1'b0;
            r_cnt            <= '0;
            r_resp_valid     <= 2'b00;
            r_resp_resultado <= 32'd0;
            r_resp_erro      <= 1'b0;
            r_ula_operando1  <= 16'd0;
            r_ula_operando2  <= 16'd0;
            r_ula_opcode     <= 5'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_sel;
                        r_prio  <= ~w_sel;
                        if (w_reject) begin
                            // ALU inputs keep their previous value on a rejected request.
                            r_resp_resultado <= 32'd0;
                            r_resp_erro      <= 1'b1;
                            r_resp_valid     <= w_sel ? 2'b10 : 2'b01;
                            r_state          <= ST_RESP;
                        end else begin
                            r_ula_operando1 <= w_op1;
                            r_ula_operando2 <= w_op2;
                            r_ula_opcode    <= w_opcode;
                            r_cnt           <= w_is_muldiv ? CNT_W'(MULDIV_CYCLES)
                                                           : CNT_W'(ALU_CYCLES);
                            r_state         <= ST_EXEC;
                        end
                    end
                end

                ST_EXEC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_resp_resultado <= bus.ula_resultado;
                        r_resp_erro      <= 1'b0;
                        r_resp_valid     <= r_owner ? 2'b10 : 2'b01;
                        r_state          <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    // Result data stays on the bus after the handshake; only valid drops.
                    if (w_owner_resp_ready) begin
                        r_resp_valid <= 2'b00;
                        r_state      <= ST_IDLE;
                    end
                end

                default: begin
                    r_resp_valid <= 2'b00;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.resp0_valid    = r_resp_valid[0];
    assign bus.resp1_valid    = r_resp_valid[1];
    assign bus.resp_resultado = r_resp_resultado;
    assign bus.resp_erro      = r_resp_erro;
    assign bus.ula_operando1  = r_ula_operando1;
    assign bus.ula_operando2  = r_ula_operando2;
    assign bus.ula_opcode     = r_ula_opcode;

endmodule
`default_nettype wire

// File: tb/tb_ula_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_arbiter_ctrl
// Description : Self-checking bench for ula_arbiter_ctrl. A behavioural ALU
//               closes the loop; directed requests push their expected
//               responses into a queue and a monitor compares each response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_arbiter_ctrl;
    import ula_arbiter_ctrl_pkg::*;

    typedef struct {
        logic        owner;
        logic [31:0] res;
        logic        err;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    exp_t expq[$];

    ula_arbiter_ctrl_if bus ();

    ula_arbiter_ctrl #(
        .ALU_CYCLES    (1),
        .MULDIV_CYCLES (4)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    logic [31:0] w_alu;
    always_comb begin
        w_alu = 32'd0;
        case (bus.ula_opcode)
            OP_PASS: w_alu = {16'd0, bus.ula_operando1};
            OP_ADD:  w_alu = {16'd0, bus.ula_operando1} + {16'd0, bus.ula_operando2};
            OP_SUB:  w_alu = {16'd0, bus.ula_operando1} - {16'd0, bus.ula_operando2};
            OP_MUL:  w_alu = {16'd0, bus.ula_operando1} * {16'd0, bus.ula_operando2};
            OP_DIV:  w_alu = (bus.ula_operando2 == 16'd0) ? 32'd0 :
                             {16'd0, bus.ula_operando1 / bus.ula_operando2};
            OP_AND:  w_alu = {16'd0, bus.ula_operando1 & bus.ula_operando2};
            OP_NAND: w_alu = {16'd0, ~(bus.ula_operando1 & bus.ula_operando2)};
            OP_OR:   w_alu = {16'd0, bus.ula_operando1 | bus.ula_operando2};
            OP_XOR:  w_alu = {16'd0, bus.ula_operando1 ^ bus.ula_operando2};
            OP_CMP:  w_alu = (bus.ula_operando1 < bus.ula_operando2) ? 32'hFFFF_FFFF :
                             (bus.ula_operando1 == bus.ula_operando2) ? 32'd0 : 32'd1;
            OP_NOT:  w_alu = {16'd0, ~bus.ula_operando1};
            default: w_alu = 32'd0;
        endcase
    end
    assign bus.ula_resultado = w_alu;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic owner, input logic [31:0] res, input logic err, input int lat);
        exp_t e;
        e.owner = owner;
        e.res   = res;
        e.err   = err;
        e.lat   = lat;
        expq.push_back(e);
    endtask

    task automatic drive(input int id, input logic [15:0] a, input logic [15:0] b, input logic [4:0] op);
        if (id == 0) begin
            bus.req0_valid = 1'b1; bus.req0_operando1 = a; bus.req0_operando2 = b; bus.req0_opcode = op;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_operando1 = a; bus.req1_operando2 = b; bus.req1_opcode = op;
        end
    endtask

    // Called at a falling edge right after driving; returns at the falling edge
    // following the last accepting rising edge.
    task automatic wait_accepts(input int want);
        int n = 0;
        for (int i = 0; i < 200 && n < want; i++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) n++;
            @(negedge clk);
        end
        chk("accept_count", 32'(n), 32'(want));
    endtask

    // Response monitor: checks owner, data, error and latency on each new
    // response, and stability of the data while it is held.
    initial begin : monitor
        int          cyc;
        int          acc_cyc;
        logic        prev_v;
        logic        v;
        logic [31:0] held_r;
        logic        held_e;
        exp_t        e;
        cyc = 0; acc_cyc = 0; prev_v = 1'b0; held_r = 32'd0; held_e = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst) begin
                prev_v = 1'b0;
                continue;
            end
            if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready))
                acc_cyc = cyc;
            v = bus.resp0_valid | bus.resp1_valid;
            if (v && !prev_v) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_response: got resp %b%b expected none (t=%0t)",
                             bus.resp1_valid, bus.resp0_valid, $time);
                end else begin
                    e = expq.pop_front();
                    chk("resp_owner",     {31'd0, bus.resp1_valid}, {31'd0, e.owner});
                    chk("resp_one_hot",   {31'd0, bus.resp0_valid & bus.resp1_valid}, 32'd0);
                    chk("resp_resultado", bus.resp_resultado, e.res);
                    chk("resp_erro",      {31'd0, bus.resp_erro}, {31'd0, e.err});
                    chk("resp_latency",   32'(cyc - acc_cyc), 32'(e.lat));
                end
                held_r = bus.resp_resultado;
                held_e = bus.resp_erro;
            end else if (v) begin
                chk("hold_resultado", bus.resp_resultado, held_r);
                chk("hold_erro",      {31'd0, bus.resp_erro}, {31'd0, held_e});
            end
            prev_v = v;
        end
    end

    initial begin : stim
        logic [15:0] s_op1;
        logic [15:0] s_op2;
        logic [4:0]  s_opc;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_operando1 = 16'd0; bus.req0_operando2 = 16'd0; bus.req0_opcode = 5'd0;
        bus.req1_valid = 1'b0; bus.req1_operando1 = 16'd0; bus.req1_operando2 = 16'd0; bus.req1_opcode = 5'd0;
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_req0_ready",  {31'd0, bus.req0_ready},  32'd0);
        chk("rst_req1_ready",  {31'd0, bus.req1_ready},  32'd0);
        chk("rst_resp0_valid", {31'd0, bus.resp0_valid}, 32'd0);
        chk("rst_resp1_valid", {31'd0, bus.resp1_valid}, 32'd0);
        chk("rst_resultado",   bus.resp_resultado,       32'd0);
        chk("rst_erro",        {31'd0, bus.resp_erro},   32'd0);
        chk("rst_ula_op1",     {16'd0, bus.ula_operando1}, 32'd0);
        chk("rst_ula_op2",     {16'd0, bus.ula_operando2}, 32'd0);
        chk("rst_ula_opcode",  {27'd0, bus.ula_opcode},    32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Contention straight after reset: 0,1,0,1
        push(1'b0, 32'd30, 1'b0, 2);
        push(1'b1, 32'd42, 1'b0, 2);
        push(1'b0, 32'd30, 1'b0, 2);
        push(1'b1, 32'd42, 1'b0, 2);
        drive(0, 16'd10, 16'd20, OP_ADD);
        drive(1, 16'd50, 16'd8,  OP_SUB);
        wait_accepts(4);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Single ADD
        push(1'b0, 32'd8, 1'b0, 2);
        drive(0, 16'd3, 16'd5, OP_ADD);
        wait_accepts(1);
        bus.req0_valid = 1'b0;

        // MUL latency
        push(1'b1, 32'd60000, 1'b0, 5);
        drive(1, 16'd300, 16'd200, OP_MUL);
        wait_accepts(1);
        bus.req1_valid = 1'b0;

        // Normal DIV
        push(1'b0, 32'd14, 1'b0, 5);
        drive(0, 16'd100, 16'd7, OP_DIV);
        wait_accepts(1);
        bus.req0_valid = 1'b0;
        repeat (8) @(negedge clk);
        s_op1 = bus.ula_operando1;
        s_op2 = bus.ula_operando2;
        s_opc = bus.ula_opcode;
        chk("div_ula_op1", {16'd0, s_op1}, 32'd100);

        // Divide by zero and unsupported opcode
        push(1'b0, 32'd0, 1'b1, 1);
        drive(0, 16'd7, 16'd0, OP_DIV);
        wait_accepts(1);
        bus.req0_valid = 1'b0;
        push(1'b0, 32'd0, 1'b1, 1);
        drive(0, 16'd1, 16'd1, 5'b00011);
        wait_accepts(1);
        bus.req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rej_ula_op1",    {16'd0, bus.ula_operando1}, {16'd0, s_op1});
        chk("rej_ula_op2",    {16'd0, bus.ula_operando2}, {16'd0, s_op2});
        chk("rej_ula_opcode", {27'd0, bus.ula_opcode},    {27'd0, s_opc});

        // Backpressure on requester 0 while requester 1 waits
        bus.resp0_ready = 1'b0;
        push(1'b0, 32'hFFFF_FFFF, 1'b0, 2);
        drive(0, 16'd2, 16'd9, OP_CMP);
        wait_accepts(1);
        bus.req0_valid = 1'b0;
        drive(1, 16'hF0F0, 16'h0FF0, OP_XOR);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
            @(negedge clk);
        end
        chk("bp_resp0_valid", {31'd0, bus.resp0_valid}, 32'd1);
        push(1'b1, 32'h0000_FF00, 1'b0, 2);
        bus.resp0_ready = 1'b1;
        wait_accepts(1);
        bus.req1_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the middle of a DIV
        drive(0, 16'd200, 16'd5, OP_DIV);
        wait_accepts(1);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_resp0_valid", {31'd0, bus.resp0_valid}, 32'd0);
        chk("mid_rst_resp1_valid", {31'd0, bus.resp1_valid}, 32'd0);
        chk("mid_rst_resultado",   bus.resp_resultado,        32'd0);
        chk("mid_rst_erro",        {31'd0, bus.resp_erro},    32'd0);
        chk("mid_rst_ula_op1",     {16'd0, bus.ula_operando1}, 32'd0);
        chk("mid_rst_ula_op2",     {16'd0, bus.ula_operando2}, 32'd0);
        chk("mid_rst_ula_opcode",  {27'd0, bus.ula_opcode},    32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        push(1'b0, 32'h0000_0F00, 1'b0, 2);
        drive(0, 16'hFF0F, 16'h0FF0, OP_AND);
        wait_accepts(1);
        bus.req0_valid = 1'b0;
        repeat (10) @(negedge clk);

        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ula_arbiter_ctrl.md
Name: ula_arbiter_ctrl

Overview:
- Shares the single combinational 16-bit ALU between two requesters (req0, req1) using round-robin arbitration and valid/ready handshakes.
- Registers the winning operands and opcode and drives them to the ALU.
- Waits a fixed number of cycles (longer for multiply/divide), captures the 32-bit result, and returns it to the requester that issued it.
- Rejects unsupported opcodes and divide-by-zero before the ALU is used.

Parameters:
- ALU_CYCLES, 1, EXEC cycles for single-cycle opcodes (>=1).
- MULDIV_CYCLES, 4, EXEC cycles for MUL (00110) and DIV (00111) (>=1).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_operando1  in  16  operand 1.
- req0_operando2  in  16  operand 2.
- req0_opcode  in  5  ALU opcode.
- req1_valid, req1_ready, req1_operando1, req1_operando2, req1_opcode: same as req0, for requester 1.
- resp0_valid  out  1  result for requester 0 is valid.
- resp0_ready  in  1  requester 0 takes the result.
- resp1_valid  out  1  result for requester 1 is valid.
- resp1_ready  in  1  requester 1 takes the result.
- resp_resultado  out  32  shared result bus.
- resp_erro  out  1  1 = opcode rejected or divide by zero.
- ula_operando1  out  16  to ALU.
- ula_operando2  out  16  to ALU.
- ula_opcode  out  5  to ALU.
- ula_resultado  in  32  from ALU (combinational).

Behaviour:
- Reset (asynchronous, any state):
  - State = IDLE, prio = 0, wait counter = 0.
  - All ready and valid outputs = 0; resp_resultado = 0, resp_erro = 0.
  - ula_* outputs = 0.
  - Any in-flight transaction is discarded; no response is ever issued for it.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Winner: if only one reqN_valid is high, that requester wins. If both are high, requester `prio` wins.
  - reqN_ready = 1 (combinational) for the winner only. The loser's ready = 0.
  - Handshake = valid & ready on the winner. On the handshake edge:
    - Latch operands, opcode and owner.
    - Set prio = ~owner.
- Validation at acceptance:
  - Supported opcodes: 00010 and 00100..01101.
  - Unsupported opcode, or DIV with operando2 == 0:
    - Skip EXEC and go directly to RESP.
    - resp_resultado = 0, resp_erro = 1.
  - Otherwise:
    - Go to EXEC and load the counter with MULDIV_CYCLES (MUL/DIV) or ALU_CYCLES (all others).
- ula_* outputs:
  - Registered copy of the latched request.
  - Updated only on acceptance of a valid, non-rejected request; otherwise hold their last value.
- EXEC:
  - Counter decrements each cycle.
  - On the cycle the counter == 1: capture ula_resultado into resp_resultado, set resp_erro = 0, go to RESP.
- RESP:
  - respN_valid = 1 for the owner only; the data is held stable until respN_ready.
  - On respN_ready: return to IDLE.
  - No request is accepted in the same cycle as the response handshake (acceptance resumes in IDLE).
  - respN_ready from the non-owner is ignored.
- Latency, accept edge T to respN_valid high:
  - T + ALU_CYCLES + 1 (i.e. 2 with defaults).
  - T + MULDIV_CYCLES + 1 for MUL/DIV.
  - T + 1 for rejected requests.
- Throughput: one operation in flight. The minimum issue interval is latency + 1 cycle.
- Requester obligation: reqN_* must hold stable while valid && !ready. The block does not check this.
- Width: results are passed through unmodified. The compare opcode's -1 result appears as 0xFFFFFFFF.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_PASS=00010, OP_ADD=00100, OP_SUB=00101, OP_MUL=00110, OP_DIV=00111, OP_AND=01000, OP_NAND=01001, OP_OR=01010, OP_XOR=01011, OP_CMP=01100, OP_NOT=01101.
  - State encoding (IDLE/EXEC/RESP).
  - The opcode_supported function.
- One sub-module, ula_rr_pick: combinational 2-way round-robin winner selection from (valid0, valid1, prio) to (grant0, grant1).
- The ALU itself stays outside the block and is connected at the top level.

Test Plan:
- Single ADD: req0 (3, 5, 00100) with resp0_ready = 1.
  - Expect req0_ready at accept; resp0_valid 2 cycles later with resultado = 8, erro = 0.
- Contention: req0 and req1 both valid after reset.
  - Expect req0 served first, then req1.
  - With both held valid, grants alternate 0, 1, 0, 1.
- MUL latency: req1 (300, 200, 00110).
  - Expect resp1_valid exactly MULDIV_CYCLES + 1 = 5 cycles after accept, resultado = 60000.
- Divide by zero and bad opcode: req0 (7, 0, 00111) and req0 (1, 1, 00011).
  - Each: resp0_valid 1 cycle after accept, resultado = 0, erro = 1.
  - ula_* outputs unchanged.
- Backpressure: CMP (2, 9) with resp0_ready = 0 for 10 cycles.
  - resp0_valid and resultado = 0xFFFFFFFF held stable.
  - No further accepts; req1_ready stays 0 throughout.
- Reset mid-operation: assert reset during EXEC of a DIV.
  - All outputs go to 0 immediately.
  - After release, no response is issued for the lost operation, and the next request is accepted normally.
